// File: rtl/gardner_pkg.sv
// Shared types and constants for the Gardner loop-gain scheduler.
package gardner_pkg;

    localparam int ERR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_LOCK  = 2'd3
    } gardner_state_e;

    localparam logic [3:0] SHIFT_ACQ_DEF = 4'd6;
    localparam logic [3:0] SHIFT_TRK_DEF = 4'd9;
    localparam logic [3:0] SHIFT_LCK_DEF = 4'd11;

    // Magnitude of a signed error; the most negative code saturates so the result fits in 15 bits.
    function automatic logic [ERR_W-1:0] abs_sat(input logic signed [ERR_W-1:0] e);
        if (e == {1'b1, {(ERR_W-1){1'b0}}})
            return {1'b0, {(ERR_W-1){1'b1}}};
        else if (e[ERR_W-1])
            return ERR_W'(-e);
        else
            return ERR_W'(e);
    endfunction

endpackage

// File: rtl/gardner_loop_ctrl_if.sv
// Signal bundle between the Gardner corrector side and the loop controller.
interface gardner_loop_ctrl_if;
    import gardner_pkg::*;

    logic                    enable;
    logic                    clk_out;
    logic signed [ERR_W-1:0] error_n;
    logic [ERR_W-1:0]        thr_lock;
    logic [ERR_W-1:0]        thr_unlock;
    logic [3:0]              GARDNER_SHIFT;
    logic                    locked;
    logic [1:0]              state;
    logic [ERR_W-1:0]        err_avg;
    logic                    win_done;

    modport master (
        output enable, clk_out, error_n, thr_lock, thr_unlock,
        input  GARDNER_SHIFT, locked, state, err_avg, win_done
    );

    modport slave (
        input  enable, clk_out, error_n, thr_lock, thr_unlock,
        output GARDNER_SHIFT, locked, state, err_avg, win_done
    );

endinterface

// File: rtl/gardner_err_window.sv
// Symbol-strobe detection and windowed mean of |error_n| over 2^WIN_LOG2 symbols.
module gardner_err_window
    import gardner_pkg::*;
#(
    parameter int WIN_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    clk_out,
    input  logic signed [ERR_W-1:0] error_n,
    output logic                    win_fire,
    output logic [ERR_W-1:0]        avg_next,
    output logic [ERR_W-1:0]        err_avg,
    output logic                    win_done
);

    localparam int ACC_W = ERR_W + WIN_LOG2;

    logic                clk_out_d;
    logic                sym_stb;
    logic [WIN_LOG2-1:0] sym_cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [ERR_W-1:0]    err_abs;

    assign sym_stb  = clk_out & ~clk_out_d;
    assign err_abs  = abs_sat(error_n);
    assign acc_sum  = acc + ACC_W'(err_abs);
    // The decision logic needs the completed mean in the same cycle as the final strobe.
    assign win_fire = sym_stb && !clear && (sym_cnt == '1);
    assign avg_next = ERR_W'(acc_sum >> WIN_LOG2);

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_out_d <= 1'b1;
            sym_cnt   <= '0;
            acc       <= '0;
            err_avg   <= '0;
            win_done  <= 1'b0;
        end else begin
            clk_out_d <= clk_out;
            win_done  <= win_fire;
            if (clear) begin
                sym_cnt <= '0;
                acc     <= '0;
            end else if (sym_stb) begin
                if (win_fire) begin
                    err_avg <= avg_next;
                    sym_cnt <= '0;
                    acc     <= '0;
                end else begin
                    sym_cnt <= sym_cnt + 1'b1;
                    acc     <= acc_sum;
                end
            end
        end
    end

endmodule

// File: rtl/gardner_loop_ctrl.sv
// Gear-shifting loop-gain scheduler with hysteretic lock detection for the Gardner timing loop.
module gardner_loop_ctrl
    import gardner_pkg::*;
#(
    parameter int         WIN_LOG2   = 6,
    parameter int         LOCK_CNT   = 4,
    parameter int         UNLOCK_CNT = 2,
    parameter logic [3:0] SHIFT_ACQ  = SHIFT_ACQ_DEF,
    parameter logic [3:0] SHIFT_TRK  = SHIFT_TRK_DEF,
    parameter logic [3:0] SHIFT_LCK  = SHIFT_LCK_DEF
) (
    input  logic               clk_32M768,
    input  logic               rst_32M768,
    gardner_loop_ctrl_if.slave bus
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);

    gardner_state_e    state_q, state_next;
    logic [GOOD_W-1:0] good_q, good_next;
    logic [BAD_W-1:0]  bad_q, bad_next;
    logic [3:0]        shift_q, shift_next;
    logic              locked_q;
    logic              win_clear;
    logic              win_fire;
    logic [ERR_W-1:0]  avg_next;
    logic              is_good;
    logic              is_bad;

    // IDLE and a disabled controller keep the window empty so every active state starts fresh.
    assign win_clear = !bus.enable || (state_q == ST_IDLE);

    gardner_err_window #(
        .WIN_LOG2(WIN_LOG2)
    ) u_window (
        .clk      (clk_32M768),
        .rst      (rst_32M768),
        .clear    (win_clear),
        .clk_out  (bus.clk_out),
        .error_n  (bus.error_n),
        .win_fire (win_fire),
        .avg_next (avg_next),
        .err_avg  (bus.err_avg),
        .win_done (bus.win_done)
    );

    assign is_bad  = (avg_next >= bus.thr_unlock);
    assign is_good = (avg_next < bus.thr_lock) && !is_bad;

    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            state_q  <= ST_IDLE;
            good_q   <= '0;
            bad_q    <= '0;
            shift_q  <= SHIFT_ACQ;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_next;
            good_q   <= good_next;
            bad_q    <= bad_next;
            shift_q  <= shift_next;
            locked_q <= (state_next == ST_LOCK);
        end
    end

    always_comb begin
        state_next = state_q;
        good_next  = good_q;
        bad_next   = bad_q;
        if (!bus.enable) begin
            state_next = ST_IDLE;
            good_next  = '0;
            bad_next   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_next = ST_ACQ;
                    good_next  = '0;
                    bad_next   = '0;
                end
                ST_ACQ: begin
                    if (win_fire && is_good) begin
                        state_next = ST_TRACK;
                        good_next  = '0;
                    end
                end
                ST_TRACK: begin
                    if (win_fire) begin
                        if (is_bad) begin
                            state_next = ST_ACQ;
                            good_next  = '0;
                        end else if (is_good) begin
                            if (good_q == GOOD_LAST) begin
                                state_next = ST_LOCK;
                                good_next  = '0;
                                bad_next   = '0;
                            end else begin
                                good_next = good_q + 1'b1;
                            end
                        end else begin
                            good_next = '0;
                        end
                    end
                end
                ST_LOCK: begin
                    if (win_fire) begin
                        if (is_bad) begin
                            if (bad_q == BAD_LAST) begin
                                state_next = ST_ACQ;
                                bad_next   = '0;
                            end else begin
                                bad_next = bad_q + 1'b1;
                            end
                        end else begin
                            bad_next = '0;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_next = SHIFT_ACQ;
        case (state_next)
            ST_TRACK: shift_next = SHIFT_TRK;
            ST_LOCK:  shift_next = SHIFT_LCK;
            default:  shift_next = SHIFT_ACQ;
        endcase
    end

    assign bus.state         = state_q;
    assign bus.GARDNER_SHIFT = shift_q;
    assign bus.locked        = locked_q;

endmodule

// File: tb/tb_gardner_loop_ctrl.sv
// Directed bench for gardner_loop_ctrl with a 4-symbol window, LOCK_CNT=4, UNLOCK_CNT=2.
module tb_gardner_loop_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    gardner_loop_ctrl_if bus ();

    gardner_loop_ctrl #(
        .WIN_LOG2   (2),
        .LOCK_CNT   (4),
        .UNLOCK_CNT (2),
        .SHIFT_ACQ  (4'd6),
        .SHIFT_TRK  (4'd9),
        .SHIFT_LCK  (4'd11)
    ) dut (
        .clk_32M768 (clk),
        .rst_32M768 (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #15 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge one clock after the strobe edge.
    task automatic apply_stimulus(input int e);
        bus.clk_out = 1'b0;
        @(negedge clk);
        bus.clk_out = 1'b1;
        bus.error_n = 16'(e);
        @(negedge clk);
    endtask

    task automatic apply_window(input int e0, input int e1, input int e2, input int e3);
        apply_stimulus(e0);
        apply_stimulus(e1);
        apply_stimulus(e2);
        apply_stimulus(e3);
    endtask

    task automatic check_window(input string tag, input int avg, input int st, input int shift, input int lk);
        check_output({tag, " win_done"}, 32'(bus.win_done), 32'd1);
        check_output({tag, " err_avg"}, 32'(bus.err_avg), 32'(avg));
        check_output({tag, " state"}, 32'(bus.state), 32'(st));
        check_output({tag, " shift"}, 32'(bus.GARDNER_SHIFT), 32'(shift));
        check_output({tag, " locked"}, 32'(bus.locked), 32'(lk));
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.enable     = 1'b0;
        bus.clk_out    = 1'b1;
        bus.error_n    = '0;
        bus.thr_lock   = '0;
        bus.thr_unlock = '0;
        repeat (3) @(negedge clk);
        check_output("rst state", 32'(bus.state), 32'd0);
        check_output("rst shift", 32'(bus.GARDNER_SHIFT), 32'd6);
        check_output("rst locked", 32'(bus.locked), 32'd0);
        check_output("rst err_avg", 32'(bus.err_avg), 32'd0);
        check_output("rst win_done", 32'(bus.win_done), 32'd0);

        // Release reset with clk_out high, then enable.
        rst = 1'b0;
        @(negedge clk);
        check_output("idle state", 32'(bus.state), 32'd0);
        check_output("idle win_done", 32'(bus.win_done), 32'd0);
        bus.enable = 1'b1;
        @(negedge clk);
        check_output("en state", 32'(bus.state), 32'd1);
        check_output("en shift", 32'(bus.GARDNER_SHIFT), 32'd6);

        // First window: mean 250 < 300 takes ACQ to TRACK.
        bus.thr_lock   = 16'd300;
        bus.thr_unlock = 16'd1000;
        apply_stimulus(100);
        check_output("A s1 win_done", 32'(bus.win_done), 32'd0);
        apply_stimulus(-300);
        check_output("A s2 win_done", 32'(bus.win_done), 32'd0);
        apply_stimulus(200);
        check_output("A s3 win_done", 32'(bus.win_done), 32'd0);
        apply_stimulus(-400);
        check_window("A", 250, 2, 9, 0);
        @(negedge clk);
        check_output("A pulse end", 32'(bus.win_done), 32'd0);

        // Four good windows from TRACK reach LOCK on the fourth.
        bus.thr_lock   = 16'd100;
        bus.thr_unlock = 16'd500;
        for (int w = 0; w < 3; w++) begin
            apply_window(50, -50, 50, -50);
            check_window("B trk", 50, 2, 9, 0);
        end
        apply_window(50, -50, 50, -50);
        check_window("B lock", 50, 3, 11, 1);

        // Hysteresis: bad, good, bad stays locked; second consecutive bad drops to ACQ.
        apply_window(600, -600, 600, -600);
        check_window("C bad1", 600, 3, 11, 1);
        apply_window(-50, 50, -50, 50);
        check_window("C good", 50, 3, 11, 1);
        apply_window(600, -600, 600, -600);
        check_window("C bad2", 600, 3, 11, 1);
        apply_window(-600, 600, -600, 600);
        check_window("C unlock", 600, 1, 6, 0);

        // Most negative error saturates rather than wrapping.
        apply_window(-32768, -32768, -32768, -32768);
        check_window("D sat", 32767, 1, 6, 0);

        // Threshold boundaries and bad-test priority.
        bus.thr_lock = 16'd250;
        apply_window(250, -250, 250, -250);
        check_window("E eq lock", 250, 1, 6, 0);
        bus.thr_lock = 16'd251;
        apply_window(250, -250, 250, -250);
        check_window("E below lock", 250, 2, 9, 0);
        bus.thr_lock   = 16'd100;
        bus.thr_unlock = 16'd300;
        apply_window(300, 300, -300, -300);
        check_window("E eq unlock", 300, 1, 6, 0);
        bus.thr_lock   = 16'd400;
        bus.thr_unlock = 16'd300;
        apply_window(350, -350, 350, -350);
        check_window("E bad wins", 350, 1, 6, 0);
        bus.thr_unlock = 16'd1000;
        apply_window(350, -350, 350, -350);
        check_window("E to trk", 350, 2, 9, 0);

        // Enable drops on the strobe that would close the window.
        apply_stimulus(20);
        apply_stimulus(20);
        apply_stimulus(20);
        bus.clk_out = 1'b0;
        @(negedge clk);
        bus.clk_out = 1'b1;
        bus.error_n = 16'd20;
        bus.enable  = 1'b0;
        @(negedge clk);
        check_output("F off win_done", 32'(bus.win_done), 32'd0);
        check_output("F off state", 32'(bus.state), 32'd0);
        check_output("F off shift", 32'(bus.GARDNER_SHIFT), 32'd6);
        check_output("F off err_avg", 32'(bus.err_avg), 32'd350);
        bus.clk_out = 1'b0;
        bus.enable  = 1'b1;
        @(negedge clk);
        check_output("F on state", 32'(bus.state), 32'd1);
        apply_stimulus(20);
        check_output("F s1 win_done", 32'(bus.win_done), 32'd0);
        apply_stimulus(-20);
        check_output("F s2 win_done", 32'(bus.win_done), 32'd0);
        apply_stimulus(20);
        check_output("F s3 win_done", 32'(bus.win_done), 32'd0);
        apply_stimulus(-20);
        check_window("F", 20, 2, 9, 0);

        // Reset mid-window discards the partial sum.
        apply_stimulus(1000);
        apply_stimulus(1000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("G rst err_avg", 32'(bus.err_avg), 32'd0);
        check_output("G rst state", 32'(bus.state), 32'd0);
        check_output("G rst shift", 32'(bus.GARDNER_SHIFT), 32'd6);
        @(negedge clk);
        check_output("G acq state", 32'(bus.state), 32'd1);
        apply_window(8, -8, 8, -8);
        check_window("G", 8, 2, 9, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gardner_loop_ctrl.md
Name: gardner_loop_ctrl

Overview:
Loop-gain scheduler and lock detector for the Gardner timing-recovery path. It watches the timing error at each recovered symbol and averages |error_n| over fixed symbol windows. From those averages it gear-shifts GARDNER_SHIFT through acquisition, tracking and locked gains, and reports lock with hysteresis. It sits beside the Gardner wrapper in the clk_32M768 domain and drives its GARDNER_SHIFT input.

Parameters:
WIN_LOG2, 6, window length = 2^WIN_LOG2 symbols (legal 1..10)
LOCK_CNT, 4, consecutive good windows in TRACK required to enter LOCK (>=1)
UNLOCK_CNT, 2, consecutive bad windows in LOCK required to drop to ACQ (>=1)
SHIFT_ACQ, 4'd6, GARDNER_SHIFT in IDLE/ACQ (wide loop)
SHIFT_TRK, 4'd9, GARDNER_SHIFT in TRACK
SHIFT_LCK, 4'd11, GARDNER_SHIFT in LOCK (narrow loop)

Ports:
clk_32M768  in  1  system clock
rst_32M768  in  1  synchronous reset, active-high
enable  in  1  controller enable; low forces IDLE
clk_out  in  1  symbol clock from Gardner corrector (clk_32M768 domain)
error_n  in  16  signed timing error from timing-error detector
thr_lock  in  16  unsigned; window average below this = good
thr_unlock  in  16  unsigned; window average >= this = bad
GARDNER_SHIFT  out  4  loop-gain shift to Gardner corrector
locked  out  1  high only in LOCK
state  out  2  0 IDLE, 1 ACQ, 2 TRACK, 3 LOCK
err_avg  out  16  last completed window mean of |error_n|
win_done  out  1  one-cycle pulse per completed window

Behaviour:
- Reset: state=IDLE, GARDNER_SHIFT=SHIFT_ACQ, locked=0, err_avg=0, win_done=0. Symbol counter, accumulator, good_cnt and bad_cnt are 0. The clk_out delay register resets to 1, so no spurious edge appears if clk_out is high at reset release.
- sym_stb = clk_out & ~clk_out_d. error_n is sampled on the sym_stb cycle only.
- abs: |error_n|, with -32768 saturated to 32767 (15 significant bits). Accumulator width is 16+WIN_LOG2 and cannot overflow.
- Window: accumulate on each sym_stb. On the stb that completes 2^WIN_LOG2 samples:
  - register err_avg = (acc + last abs) >> WIN_LOG2;
  - clear acc and the counter;
  - pulse win_done the next cycle.
  - state, GARDNER_SHIFT and locked update in that same cycle as win_done (latency 1 clock after the final stb).
- Window decision (avg = new err_avg):
  - IDLE: windows are not counted. enable=1 -> ACQ the next cycle; acc is cleared.
  - ACQ: avg < thr_lock -> TRACK, good_cnt=0. Otherwise stay.
  - TRACK:
    - avg >= thr_unlock -> ACQ.
    - avg < thr_lock -> good_cnt+1; when good_cnt reaches LOCK_CNT -> LOCK, bad_cnt=0.
    - otherwise good_cnt=0.
  - LOCK:
    - avg >= thr_unlock -> bad_cnt+1; when bad_cnt reaches UNLOCK_CNT -> ACQ.
    - otherwise bad_cnt=0.
  - If thr_lock > thr_unlock, the bad test wins.
- GARDNER_SHIFT is a registered decode of state: IDLE/ACQ -> SHIFT_ACQ, TRACK -> SHIFT_TRK, LOCK -> SHIFT_LCK. locked = (state==LOCK), registered.
- Each state transition restarts the window (acc and counter cleared), so no window spans a gain change.
- enable=0 has priority over everything. The next cycle gives IDLE, counters cleared, and no win_done.
- A sym_stb that coincides with enable falling is discarded.
- Reset mid-window discards the partial sum. err_avg returns to 0.
- thr_lock and thr_unlock are sampled only at window decisions and may change at any time.

Decomposition:
- Shared package gardner_pkg holds:
  - state encoding constants ST_IDLE/ST_ACQ/ST_TRACK/ST_LOCK;
  - default shift constants;
  - the error width constant ERR_W=16.
- One natural sub-module: gardner_err_window. It contains the edge detect, abs/saturate, accumulator, symbol counter, err_avg and win_done. The top holds the FSM, the hysteresis counters and the shift decode.

Test Plan:
1. Reset release with clk_out held high, then enable=1 -> no win_done for the first 64 stbs; state 0->1 one cycle after enable; GARDNER_SHIFT=6.
2. WIN_LOG2=2, error_n=+100,-300,+200,-400, thr_lock=300 -> err_avg=250 exactly 1 clock after the 4th stb; state ACQ->TRACK; GARDNER_SHIFT=9.
3. LOCK_CNT=4, error_n=±50 constant, thr_lock=100, thr_unlock=500 -> 1 window to TRACK, 4 more to LOCK; locked=1, GARDNER_SHIFT=11 on the 5th win_done.
4. In LOCK, UNLOCK_CNT=2: bad window (|e|=600), good window, bad window -> stays LOCK; two consecutive bad windows -> ACQ, locked=0, shift=6.
5. error_n=-32768 for a full window -> err_avg=32767, not wrapped.
6. enable dropped mid-window in TRACK -> IDLE next cycle, no win_done; re-enable -> fresh ACQ window of full length.
